kuz_core_arbiter: RTL and testbench
===================================

Name: kuz_core_arbiter

Overview:
- Shares one kuznyechik block-cipher core between N_REQ independent requesters.
- Round-robin grant; latches the winner's key, mode and block, then drives the core's start/busy/done interface.
- Returns the result to the owning requester on a valid/ready response channel.
- Watchdog turns a missing core_done into an error response; the arbiter drains the core before the next issue.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 1023, max cycles from core_start to core_done before error (must cover key schedule plus rounds).
- KEY_W, 256, key width.
- BLK_W, 128, block width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  one-hot accept pulse.
- req_mode  in  N_REQ  per-requester mode, 0=encrypt 1=decrypt.
- req_key  in  N_REQ*KEY_W  per-requester key, requester i at slice i.
- req_block  in  N_REQ*BLK_W  per-requester input block.
- rsp_valid  out  N_REQ  one-hot response valid.
- rsp_ready  in  N_REQ  per-requester response ready.
- rsp_data  out  BLK_W  result, shared by all requesters.
- rsp_err  out  1  response is a timeout error.
- grant_id  out  $clog2(N_REQ)  index of the current owner.
- arb_busy  out  1  FSM not in IDLE.
- core_start  out  1  single-cycle start pulse to core.
- core_mode  out  1  latched mode.
- core_key  out  KEY_W  latched key.
- core_block_in  out  BLK_W  latched block.
- core_block_out  in  BLK_W  core result, valid while core_done=1.
- core_busy  in  1  core busy.
- core_done  in  1  single-cycle core completion pulse.

Behaviour:
- Reset values: all outputs 0. FSM=IDLE, rr_ptr=0, watchdog=0.
- Reset mid-operation:
  - Outputs clear immediately and any in-flight transaction is dropped.
  - The core is not reset by this block. The first post-reset issue still waits for core_busy=0.
- FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - Search req_valid starting at rr_ptr, ascending with wrap.
  - On a winner i: req_ready[i]=1 for that cycle; latch mode, key and block into core_* regs; grant_id=i; rr_ptr=i+1 mod N_REQ; go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE:
  - If core_busy=0: core_start=1 for exactly one cycle, clear watchdog, go to WAIT.
  - Otherwise hold in ISSUE with core_start=0.
- WAIT:
  - Watchdog increments each cycle.
  - On core_done: capture core_block_out into rsp_data, rsp_err=0, go to RESP.
  - If watchdog reaches TIMEOUT with no done: rsp_data=0, rsp_err=1, go to RESP and set the drain flag.
  - core_done and timeout in the same cycle: done wins and the drain flag stays clear.
- RESP:
  - rsp_valid[grant_id]=1 until rsp_ready[grant_id]=1. The transfer occurs in the cycle both are high.
  - Next state is DRAIN if the drain flag is set, else IDLE.
  - rsp_data, rsp_err and grant_id are stable while rsp_valid is high.
- DRAIN: wait for core_busy=0, discarding any core_done, then clear the drain flag and go to IDLE.
- core_done outside WAIT is ignored.
- Latency, no contention, core idle:
  - Accept at T, core_start at T+1.
  - core_done at T+1+L gives rsp_valid at T+2+L.
  - Earliest next accept is the cycle after the response handshake.
- Single outstanding transaction; no request queueing. req_valid from non-granted requesters is held by the requesters (standard valid/ready, no drop).
- Fairness: a requester holding req_valid is granted within N_REQ transactions.
- Key handling is transparent: the core decides whether to rerun key expansion on a key change; the arbiter only waits on done.

Decomposition:
- Shared package kuz_pkg:
  - KEY_W=256 and BLK_W=128 constants.
  - Mode encoding typedef (ENC=0, DEC=1).
  - FSM state enum.
  - GOST A.1 test-vector constants for benches.
- Sub-module rr_arbiter (N-way round-robin, one-hot grant plus index, advance input) is natural and reusable.
- The top holds the FSM, latches and watchdog.

Test Plan:
- Single encrypt: requester 0, key 8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef, block 1122334455667700ffeeddccbbaa9988, mode 0 -> rsp_valid[0] with rsp_data 7f679d90bebc24305a468d42b9d4edcd, rsp_err 0, exactly one core_start.
- Decrypt: requester 2, same key, block 7f679d90bebc24305a468d42b9d4edcd, mode 1 -> rsp_valid[2], rsp_data 1122334455667700ffeeddccbbaa9988.
- Contention: all 4 requesters valid at once with rr_ptr=0 -> grant order 0,1,2,3; on re-assert the order continues 0,1,2,3; each rsp_valid is one-hot to the matching requester.
- Backpressure: rsp_ready low for 20 cycles -> rsp_valid and rsp_data held stable, no new req_ready, no core_start.
- Timeout: core model never asserts done, TIMEOUT=16:
  - rsp_err=1 and rsp_data=0 after 16 WAIT cycles.
  - The FSM stays in DRAIN while the model holds core_busy=1.
  - A late core_done is ignored, and the next request issues only after core_busy falls.
- Reset mid-WAIT: assert rst_n during WAIT -> all outputs 0 immediately; after release, a new request is served correctly; with core_busy=1, core_start waits until it falls.

Source files
------------

// File: rtl/kuz_pkg.sv
// Shared types and constants for the kuznyechik core arbiter and its benches.
// Reference vectors are the GOST R 34.12-2015 A.1 key/plaintext/ciphertext.
package kuz_pkg;

    localparam int KEY_W = 256;
    localparam int BLK_W = 128;

    typedef enum logic {
        ENC = 1'b0,
        DEC = 1'b1
    } kuz_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } arb_state_e;

    localparam logic [KEY_W-1:0] TV_KEY =
        256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
    localparam logic [BLK_W-1:0] TV_PT = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [BLK_W-1:0] TV_CT = 128'h7f679d90bebc24305a468d42b9d4edcd;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: searches upward from the pointer with wrap,
// and moves the pointer past the winner when advance is pulsed.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (gnt_valid) gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ptr <= '0;
        end else if (advance && gnt_valid) begin
            ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/kuz_core_arbiter.sv
// Shares one kuznyechik core between N_REQ requesters: round-robin accept,
// single outstanding transaction, watchdog-to-error and core drain on timeout.
module kuz_core_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1023,
    parameter int KEY_W   = kuz_pkg::KEY_W,
    parameter int BLK_W   = kuz_pkg::BLK_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ-1:0]           req_mode,
    input  logic [N_REQ*KEY_W-1:0]     req_key,
    input  logic [N_REQ*BLK_W-1:0]     req_block,
    output logic [N_REQ-1:0]           rsp_valid,
    input  logic [N_REQ-1:0]           rsp_ready,
    output logic [BLK_W-1:0]           rsp_data,
    output logic                       rsp_err,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       arb_busy,
    output logic                       core_start,
    output logic                       core_mode,
    output logic [KEY_W-1:0]           core_key,
    output logic [BLK_W-1:0]           core_block_in,
    input  logic [BLK_W-1:0]           core_block_out,
    input  logic                       core_busy,
    input  logic                       core_done
);
    import kuz_pkg::*;

    // IDLE: arbitrate | ISSUE: wait core idle, pulse start | WAIT: await done/timeout
    // RESP: hold response until ready | DRAIN: let a timed-out core finish
    localparam int IW   = $clog2(N_REQ);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    arb_state_e        state, state_nxt;
    logic [N_REQ-1:0]  gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_valid;
    logic              advance;
    logic [IW-1:0]     owner;
    kuz_mode_e         mode_q;
    logic [KEY_W-1:0]  key_q;
    logic [BLK_W-1:0]  blk_q;
    logic [BLK_W-1:0]  rsp_data_q;
    logic              rsp_err_q;
    logic              drain_q;
    logic [WD_W-1:0]   wd_q;
    logic              wd_expire;

    logic [KEY_W-1:0]  key_arr [N_REQ];
    logic [BLK_W-1:0]  blk_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign key_arr[i] = req_key[i*KEY_W +: KEY_W];
        assign blk_arr[i] = req_block[i*BLK_W +: BLK_W];
    end

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (advance),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign wd_expire = (wd_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt  = state;
        advance    = 1'b0;
        core_start = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (gnt_valid) begin
                    advance   = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!core_busy) begin
                    core_start = 1'b1;
                    state_nxt  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_done || wd_expire) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[owner]) state_nxt = drain_q ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (!core_busy) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= ST_IDLE;
            owner      <= '0;
            mode_q     <= ENC;
            key_q      <= '0;
            blk_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            drain_q    <= 1'b0;
            wd_q       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        owner  <= gnt_idx;
                        mode_q <= kuz_mode_e'(req_mode[gnt_idx]);
                        key_q  <= key_arr[gnt_idx];
                        blk_q  <= blk_arr[gnt_idx];
                    end
                end
                ST_ISSUE: begin
                    if (!core_busy) wd_q <= '0;
                end
                ST_WAIT: begin
                    wd_q <= wd_q + 1'b1;
                    // done has priority so a just-in-time completion is not flagged for drain
                    if (core_done) begin
                        rsp_data_q <= core_block_out;
                        rsp_err_q  <= 1'b0;
                    end else if (wd_expire) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        drain_q    <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!core_busy) drain_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Grant is combinational from req_valid, so it is masked while reset is held
    assign req_ready     = (state == ST_IDLE && !rst_n) ? gnt : '0;
    assign rsp_valid     = (state == ST_RESP) ? (N_REQ'(1) << owner) : '0;
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;
    assign grant_id      = owner;
    assign arb_busy      = (state != ST_IDLE);
    assign core_mode     = mode_q;
    assign core_key      = key_q;
    assign core_block_in = blk_q;

endmodule

// File: tb/tb_kuz_core_arbiter.sv
// Scoreboard bench for kuz_core_arbiter with a behavioural core model that
// maps the GOST A.1 vectors and otherwise applies a simple reversible mix.
module tb_kuz_core_arbiter;
    import kuz_pkg::*;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int KW = 256;
    localparam int BW = 128;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid, req_ready, req_mode, rsp_valid, rsp_ready;
    logic [N*KW-1:0] req_key;
    logic [N*BW-1:0] req_block;
    logic [BW-1:0]   rsp_data;
    logic            rsp_err;
    logic [1:0]      grant_id;
    logic            arb_busy, core_start, core_mode;
    logic [KW-1:0]   core_key;
    logic [BW-1:0]   core_block_in, core_block_out;
    logic            core_busy, core_done;

    // core model state
    logic            cm_busy = 1'b0;
    logic            cm_done = 1'b0;
    int              cm_cnt = 0;
    logic [BW-1:0]   cm_out = '0;
    logic            cm_m = 1'b0;
    logic [KW-1:0]   cm_k = '0;
    logic [BW-1:0]   cm_b = '0;
    int              cm_lat = 5;
    bit              cm_no_done = 1'b0;
    bit              cm_release = 1'b0;
    logic            inj_done = 1'b0;

    assign core_busy      = cm_busy;
    assign core_done      = cm_done | inj_done;
    assign core_block_out = cm_out;

    always #5 clk = ~clk;

    kuz_core_arbiter #(.N_REQ(N), .TIMEOUT(TO), .KEY_W(KW), .BLK_W(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_key(req_key), .req_block(req_block),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .grant_id(grant_id), .arb_busy(arb_busy),
        .core_start(core_start), .core_mode(core_mode), .core_key(core_key),
        .core_block_in(core_block_in), .core_block_out(core_block_out),
        .core_busy(core_busy), .core_done(core_done)
    );

    function automatic logic [BW-1:0] core_f(input logic m, input logic [KW-1:0] k,
                                             input logic [BW-1:0] b);
        if (k == TV_KEY && !m && b == TV_PT) return TV_CT;
        if (k == TV_KEY &&  m && b == TV_CT) return TV_PT;
        return b ^ k[BW-1:0] ^ {BW{m}} ^ 128'h5a5a_0000_ffff_1234_0f0f_aaaa_5555_c3c3;
    endfunction

    always @(posedge clk) begin
        cm_done <= 1'b0;
        if (core_start) begin
            cm_busy <= 1'b1;
            cm_cnt  <= cm_lat;
            cm_m    <= core_mode;
            cm_k    <= core_key;
            cm_b    <= core_block_in;
        end else if (cm_busy) begin
            if (cm_done) cm_busy <= 1'b0;
            else if (cm_no_done) begin
                if (cm_release) cm_busy <= 1'b0;
            end else if (cm_cnt > 1) cm_cnt <= cm_cnt - 1;
            else begin
                cm_done <= 1'b1;
                cm_out  <= core_f(cm_m, cm_k, cm_b);
            end
        end
    end

    typedef struct {
        int            id;
        logic [BW-1:0] data;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0, last_acc = -1, last_start = -1, last_done = -1;
    int   n_start = 0, n_acc = 0;
    bit   prev_rv = 1'b0;

    task automatic chk(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [N-1:0] acc;
        exp_t         e;
        @(negedge clk);
        cyc++;
        acc = req_valid & req_ready;
        if (core_done) last_done = cyc;
        if (core_start) begin
            n_start++;
            last_start = cyc;
            chk("start_while_busy", core_busy, 1'b0);
        end
        if (acc != 0) begin
            n_acc++;
            last_acc = cyc;
            chk("ready_onehot", $countones(acc), 1);
        end
        if (rsp_valid != 0) begin
            chk("resp_no_ready", req_ready, 0);
            chk("resp_no_start", core_start, 0);
            if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
            else begin
                e = exp_q[0];
                chk("rsp_valid", rsp_valid, 4'b1 << e.id);
                chk("grant_id", grant_id, e.id);
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", rsp_err, e.err);
                if (!prev_rv) chk("rsp_lat", cyc, e.err ? last_start + TO + 1 : last_done + 1);
                if ((rsp_valid & rsp_ready) != 0) void'(exp_q.pop_front());
            end
        end
        prev_rv = ((rsp_valid & ~rsp_ready) != 0);
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic set_req(input int id, input logic m, input logic [KW-1:0] k,
                           input logic [BW-1:0] b, input logic err);
        exp_t e;
        req_mode[id]           = m;
        req_key[id*KW +: KW]   = k;
        req_block[id*BW +: BW] = b;
        req_valid[id]          = 1'b1;
        e.id   = id;
        e.data = err ? '0 : core_f(m, k, b);
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic drain_sb(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("sb_drain", exp_q.size(), 0);
    endtask

    function automatic logic [KW-1:0] rnd_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [BW-1:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
        chk({tag, "_arb_busy"}, arb_busy, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_core_mode"}, core_mode, 0);
        chk({tag, "_core_key"}, core_key, 0);
        chk({tag, "_core_blk"}, core_block_in, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int s0, a0, acc_c, n, rel_cyc;
        req_valid = '0; req_mode = '0; req_key = '0; req_block = '0; rsp_ready = '1;
        repeat (3) @(posedge clk);
        #1;
        req_valid[1] = 1'b1;
        #1;
        check_idle_outputs("reset");
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        step();

        // single encrypt, GOST vector
        s0 = n_start; a0 = n_acc;
        set_req(0, 1'b0, TV_KEY, TV_PT, 1'b0);
        step();
        chk("enc_accept", n_acc - a0, 1);
        acc_c = last_acc;
        step();
        chk("enc_start_lat", last_start, acc_c + 1);
        chk("enc_core_key", core_key, TV_KEY);
        chk("enc_core_blk", core_block_in, TV_PT);
        chk("enc_core_mode", core_mode, 1'b0);
        drain_sb(100);
        chk("enc_one_start", n_start - s0, 1);

        // decrypt on requester 2
        set_req(2, 1'b1, TV_KEY, TV_CT, 1'b0);
        drain_sb(100);
        chk("dec_core_mode", core_mode, 1'b1);
        chk("dec_core_blk", core_block_in, TV_CT);

        // requester 3 brings the pointer back to 0
        set_req(3, 1'b0, rnd_key(), rnd_blk(), 1'b0);
        drain_sb(100);

        // contention from pointer 0, twice
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'(i & 1), rnd_key(), rnd_blk(), 1'b0);
            drain_sb(400);
        end

        // pointer at 2 after serving requester 1: order becomes 2,3,0,1
        set_req(1, 1'b0, rnd_key(), rnd_blk(), 1'b0);
        drain_sb(100);
        for (int i = 0; i < N; i++) set_req((i + 2) % N, 1'b1, rnd_key(), rnd_blk(), 1'b0);
        drain_sb(400);

        // backpressure on requester 1 while requester 3 waits
        rsp_ready[1] = 1'b0;
        set_req(1, 1'b0, rnd_key(), rnd_blk(), 1'b0);
        n = 0;
        while (rsp_valid == 0 && n < 100) begin step(); n++; end
        chk("bp_rsp_seen", rsp_valid, 4'b0010);
        set_req(3, 1'b1, rnd_key(), rnd_blk(), 1'b0);
        s0 = n_start; a0 = n_acc;
        repeat (20) step();
        chk("bp_held", rsp_valid, 4'b0010);
        chk("bp_no_accept", n_acc - a0, 0);
        chk("bp_no_start", n_start - s0, 0);
        rsp_ready[1] = 1'b1;
        drain_sb(200);

        // timeout: core never completes, then drains
        cm_no_done = 1'b1;
        set_req(0, 1'b0, rnd_key(), rnd_blk(), 1'b1);
        drain_sb(100);
        set_req(1, 1'b0, rnd_key(), rnd_blk(), 1'b0);
        a0 = n_acc; s0 = n_start;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("drain_busy", arb_busy, 1'b1);
        end
        inj_done = 1'b1;
        step();
        inj_done = 1'b0;
        repeat (3) step();
        chk("late_done_rsp", rsp_valid, 0);
        chk("late_done_busy", arb_busy, 1'b1);
        chk("drain_no_accept", n_acc - a0, 0);
        chk("drain_no_start", n_start - s0, 0);
        cm_release = 1'b1;
        rel_cyc = cyc;
        step();
        cm_release = 1'b0;
        cm_no_done = 1'b0;
        drain_sb(200);
        chk("drain_then_accept", last_acc > rel_cyc + 1, 1'b1);

        // reset during WAIT, core stays busy across it
        cm_lat = 12;
        set_req(2, 1'b1, rnd_key(), rnd_blk(), 1'b0);
        s0 = n_start; n = 0;
        while (n_start == s0 && n < 50) begin step(); n++; end
        chk("rst_started", n_start - s0, 1);
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        exp_q.delete();
        req_valid = '0;
        prev_rv = 1'b0;
        repeat (2) step();
        rst_n = 1'b0;
        cm_lat = 5;
        s0 = n_start; a0 = n_acc;
        set_req(0, 1'b0, TV_KEY, TV_PT, 1'b0);
        step();
        chk("post_rst_accept", n_acc - a0, 1);
        chk("post_rst_core_busy", core_busy, 1'b1);
        drain_sb(200);
        chk("post_rst_start_wait", last_start - last_acc > 1, 1'b1);
        chk("post_rst_one_start", n_start - s0, 1);
        repeat (5) step();
        chk("end_idle", arb_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
